// File: rtl/relu_maxpool_stage_if.sv
// Bundle between relu_maxpool_stage and its neighbours.
//   data_i : packed input map, K slots x H positions, index 0 = MSB
//   done_i : upstream completion flag (rising edge starts a run)
//   data_o : pooled map, K slots x H/P positions, same packing
//   done_o : one-cycle pulse when data_o holds a new result
//   busy_o : high while the stage is processing slots
// master drives the inputs of the stage, slave is the stage itself.
interface relu_maxpool_stage_if #(
  parameter int unsigned H          = 24,
  parameter int unsigned K          = 8,
  parameter int unsigned P          = 2,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [0:H*K*DATA_WIDTH-1]     data_i;
  logic                          done_i;
  logic [0:(H/P)*K*DATA_WIDTH-1] data_o;
  logic                          done_o;
  logic                          busy_o;

  modport master (
    output data_i,
    output done_i,
    input  data_o,
    input  done_o,
    input  busy_o
  );

  modport slave (
    input  data_i,
    input  done_i,
    output data_o,
    output done_o,
    output busy_o
  );
endinterface

// File: rtl/relu_maxpool_stage.sv
// ReLU + 1-D max pooling stage (window P, stride P) after bias-add/saturate.
// On a rising edge of done_i the input map is captured; one channel slot is
// pooled per cycle for K cycles, then the whole result is published on
// data_o together with a one-cycle done_o pulse.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active HIGH (in reset while rst_n = 1)
//   bus   : relu_maxpool_stage_if.slave (data_i, done_i, data_o, done_o, busy_o)
module relu_maxpool_stage #(
  parameter int unsigned H          = 24,
  parameter int unsigned K          = 8,
  parameter int unsigned P          = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  relu_maxpool_stage_if.slave  bus
);

  localparam int unsigned HO     = H / P;
  localparam int unsigned SlotW  = H * DATA_WIDTH;
  localparam int unsigned OSlotW = HO * DATA_WIDTH;
  localparam int unsigned InW    = SlotW * K;
  localparam int unsigned OutW   = OSlotW * K;
  localparam int unsigned CntW   = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [0:InW-1]      cap_q, cap_d;
  logic [0:OutW-1]     work_q, work_d;
  logic [0:OutW-1]     data_q, data_d;
  logic                done_prev_q;
  logic                trigger;
  logic [0:SlotW-1]    slot_sel;
  logic [0:OSlotW-1]   pooled;

  // Pool one slot: per window a pairwise max-reduction tree, then ReLU.
  // The result is never negative so no saturation is required.
  function automatic logic [0:OSlotW-1] pool_slot(input logic [0:SlotW-1] slot);
    logic [0:OSlotW-1]             res;
    logic signed [DATA_WIDTH-1:0]  lvl [P];
    res = '0;
    for (int w = 0; w < int'(HO); w++) begin
      for (int k = 0; k < int'(P); k++) begin
        lvl[k] = slot[(w*int'(P)+k)*int'(DATA_WIDTH) +: DATA_WIDTH];
      end
      for (int s = 1; s < int'(P); s = s * 2) begin
        for (int i = 0; i + s < int'(P); i = i + 2 * s) begin
          if (lvl[i+s] > lvl[i]) lvl[i] = lvl[i+s];
        end
      end
      res[w*int'(DATA_WIDTH) +: DATA_WIDTH] = lvl[0][DATA_WIDTH-1] ? '0 : lvl[0];
    end
    return res;
  endfunction

  assign trigger  = bus.done_i & ~done_prev_q;
  // Only one slot goes through the comparator trees per cycle.
  assign slot_sel = cap_q[int'(cnt_q)*int'(SlotW) +: SlotW];
  assign pooled   = pool_slot(slot_sel);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    work_d  = work_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (trigger) begin
          cap_d   = bus.data_i;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        work_d[int'(cnt_q)*int'(OSlotW) +: OSlotW] = pooled;
        if (cnt_q == CntW'(K - 1)) begin
          // Publish including the slot written this cycle.
          data_d  = work_d;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (trigger) begin
          cap_d   = bus.data_i;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cap_q       <= '0;
      work_q      <= '0;
      data_q      <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      work_q      <= work_d;
      data_q      <= data_d;
      done_prev_q <= bus.done_i;
    end
  end

  assign bus.data_o = data_q;
  assign bus.done_o = (state_q == StDone);
  assign bus.busy_o = (state_q == StRun);

endmodule

// File: tb/tb_relu_maxpool_stage.sv
module tb_relu_maxpool_stage;
  localparam int H  = 24;
  localparam int K  = 8;
  localparam int P  = 2;
  localparam int DW = 8;
  localparam int HO = H / P;
  localparam int IW = H * K * DW;
  localparam int OW = HO * K * DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  relu_maxpool_stage_if #(.H(H), .K(K), .P(P), .DATA_WIDTH(DW)) bus ();

  relu_maxpool_stage #(.H(H), .K(K), .P(P), .DATA_WIDTH(DW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: for every slot and window take the signed maximum, clamp below at 0.
  function automatic logic [0:OW-1] ref_pool(input logic [0:IW-1] d);
    logic [0:OW-1] r;
    logic [7:0]    b;
    int            best, v;
    r = '0;
    for (int m = 0; m < K; m++) begin
      for (int w = 0; w < HO; w++) begin
        best = -100000;
        for (int k = 0; k < P; k++) begin
          b = d[(m*H + w*P + k)*8 +: 8];
          v = int'($signed(b));
          if (v > best) best = v;
        end
        if (best < 0) best = 0;
        r[(m*HO + w)*8 +: 8] = 8'(best);
      end
    end
    return r;
  endfunction

  function automatic logic [0:IW-1] fill_in(input logic [7:0] b);
    logic [0:IW-1] d;
    for (int i = 0; i < H*K; i++) d[i*8 +: 8] = b;
    return d;
  endfunction

  function automatic logic [0:OW-1] fill_out(input logic [7:0] b);
    logic [0:OW-1] d;
    for (int i = 0; i < HO*K; i++) d[i*8 +: 8] = b;
    return d;
  endfunction

  function automatic logic [0:IW-1] rand_in();
    logic [0:IW-1] d;
    for (int i = 0; i < H*K; i++) d[i*8 +: 8] = 8'($urandom_range(0, 255));
    return d;
  endfunction

  // Triggers a run with din, then observes n cycles. done_i stays high for
  // pulse_len cycles; optionally a second one-cycle pulse with rdin at retrig_at.
  // Input data is scrambled after the capture edge to prove it was latched.
  task automatic run_window(input logic [0:IW-1] din, input int pulse_len,
                            input int retrig_at, input logic [0:IW-1] rdin, input int n,
                            output int first_done, output int n_done, output int n_busy,
                            output int n_unstable, output logic [0:OW-1] d1,
                            output logic [0:OW-1] d2);
    logic [0:OW-1] prev;
    first_done = -1; n_done = 0; n_busy = 0; n_unstable = 0; d1 = '0; d2 = '0;
    @(negedge clk);
    bus.done_i = 1'b0;
    bus.data_i = din;
    @(negedge clk);
    prev = bus.data_o;
    bus.done_i = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (bus.done_o) begin
        n_done++;
        if (n_done == 1) begin
          first_done = c;
          d1 = bus.data_o;
        end else begin
          d2 = bus.data_o;
        end
      end
      if (bus.busy_o) n_busy++;
      if (bus.data_o !== prev && !bus.done_o) n_unstable++;
      prev = bus.data_o;
      if (c == pulse_len) bus.done_i = 1'b0;
      if (c == 1) bus.data_i = rand_in();
      if (retrig_at > 0 && c == retrig_at) begin
        bus.done_i = 1'b1;
        bus.data_i = rdin;
      end else if (retrig_at > 0 && c == retrig_at + 1) begin
        bus.done_i = 1'b0;
      end
    end
    bus.done_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.done_i = 1'b0;
    bus.data_i = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.data_o !== '0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got done=%b busy=%b data_nz=%b, required 0 0 0",
                 bus.done_o, bus.busy_o, |bus.data_o);
      end
    end
    rst_n = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.data_o !== '0 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got done=%b busy=%b data_nz=%b, required 0 0 0",
                 c, bus.done_o, bus.busy_o, |bus.data_o);
      end
    end
  endtask

  task automatic test_basic_pool();
    logic [0:IW-1] din;
    logic [0:OW-1] d1, d2, exp;
    int fd, nd, nb, nu;
    logic [7:0] s0 [6];
    s0 = '{8'd1, 8'd5, 8'hFD, 8'hF9, 8'd127, 8'h80};
    din = fill_in(8'h10);
    for (int j = 0; j < H; j++) din[j*8 +: 8] = (j < 6) ? s0[j] : 8'h00;
    exp = ref_pool(din);
    run_window(din, 1, 0, '0, 14, fd, nd, nb, nu, d1, d2);
    n_tests++;
    if (fd !== K + 1) begin
      n_fail++; $display("FAIL basic_latency: got %0d required %0d", fd, K + 1);
    end
    n_tests++;
    if (nd !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d required 1", nd); end
    n_tests++;
    if (nb !== K) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d required %0d", nb, K); end
    n_tests++;
    if (d1[0:23] !== {8'd5, 8'd0, 8'd127}) begin
      n_fail++; $display("FAIL basic_slot0_head: got %h required 05007f", d1[0:23]);
    end
    n_tests++;
    if (d1 !== exp) begin
      n_fail++; $display("FAIL basic_map: got %h required %h", d1, exp);
    end
  endtask

  task automatic test_all_negative();
    logic [0:OW-1] d1, d2;
    int fd, nd, nb, nu;
    run_window(fill_in(8'hFF), 1, 0, '0, 14, fd, nd, nb, nu, d1, d2);
    n_tests++;
    if (nd !== 1) begin n_fail++; $display("FAIL neg_done_count: got %0d required 1", nd); end
    n_tests++;
    if (d1 !== fill_out(8'h00)) begin
      n_fail++; $display("FAIL neg_map: got %h required all zero", d1);
    end
  endtask

  task automatic test_level_retrigger();
    logic [0:IW-1] din;
    logic [0:OW-1] d1, d2;
    int fd, nd, nb, nu;
    din = rand_in();
    run_window(din, 30, 0, '0, 40, fd, nd, nb, nu, d1, d2);
    n_tests++;
    if (nd !== 1) begin n_fail++; $display("FAIL level_done_count: got %0d required 1", nd); end
    n_tests++;
    if (d1 !== ref_pool(din)) begin
      n_fail++; $display("FAIL level_map: got %h required %h", d1, ref_pool(din));
    end
    din = rand_in();
    run_window(din, 1, 3, rand_in(), 20, fd, nd, nb, nu, d1, d2);
    n_tests++;
    if (nd !== 1 || fd !== K + 1) begin
      n_fail++; $display("FAIL retrig_ignored: got %0d pulses first at %0d required 1 at %0d",
                         nd, fd, K + 1);
    end
    n_tests++;
    if (d1 !== ref_pool(din)) begin
      n_fail++; $display("FAIL retrig_map: got %h required %h", d1, ref_pool(din));
    end
  endtask

  task automatic test_back_to_back();
    logic [0:IW-1] din;
    logic [0:OW-1] d1, d2;
    int fd, nd, nb, nu;
    din = rand_in();
    run_window(din, 1, K + 1, fill_in(8'h22), 2*K + 6, fd, nd, nb, nu, d1, d2);
    n_tests++;
    if (nd !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d required 2", nd); end
    n_tests++;
    if (d1 !== ref_pool(din)) begin
      n_fail++; $display("FAIL b2b_first_map: got %h required %h", d1, ref_pool(din));
    end
    n_tests++;
    if (d2 !== fill_out(8'h22)) begin
      n_fail++; $display("FAIL b2b_second_map: got %h required all 22", d2);
    end
    n_tests++;
    if (nu !== 0) begin n_fail++; $display("FAIL b2b_stable: got %0d changes required 0", nu); end
  endtask

  task automatic test_reset_mid_run();
    logic [0:IW-1] din;
    logic [0:OW-1] d1, d2;
    int fd, nd, nb, nu, seen;
    @(negedge clk);
    bus.done_i = 1'b0;
    bus.data_i = rand_in();
    @(negedge clk);
    bus.done_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) bus.done_i = 1'b0;
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.data_o !== '0 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL midreset_clear: got busy=%b data_nz=%b required 0 0",
                         bus.busy_o, |bus.data_o);
    end
    @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done_o) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d required 0", seen); end
    din = rand_in();
    run_window(din, 1, 0, '0, 14, fd, nd, nb, nu, d1, d2);
    n_tests++;
    if (nd !== 1 || fd !== K + 1 || d1 !== ref_pool(din)) begin
      n_fail++; $display("FAIL midreset_recover: got %0d pulses at %0d map %h required 1 at %0d map %h",
                         nd, fd, d1, K + 1, ref_pool(din));
    end
  endtask

  task automatic test_random();
    logic [0:IW-1] din;
    logic [0:OW-1] d1, d2;
    int fd, nd, nb, nu;
    for (int r = 0; r < 4; r++) begin
      din = rand_in();
      run_window(din, 1 + r, 0, '0, 14, fd, nd, nb, nu, d1, d2);
      n_tests++;
      if (nd !== 1 || fd !== K + 1 || d1 !== ref_pool(din)) begin
        n_fail++; $display("FAIL random_%0d: got %0d pulses at %0d map %h required 1 at %0d map %h",
                           r, nd, fd, d1, K + 1, ref_pool(din));
      end
    end
  endtask

  initial begin
    bus.done_i = 1'b0;
    bus.data_i = '0;
    test_reset();
    test_basic_pool();
    test_all_negative();
    test_level_retrigger();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
